// File: rtl/key_operand_entry_if.sv
// key_operand_entry_if: operator key/switch inputs and operand/start outputs of the entry block.
interface key_operand_entry_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    logic [2:0]                     key_n;
    logic [DIGIT_W-1:0]             sw_digit;
    logic                           busy;
    logic                           start;
    logic [DIGITS*DIGIT_W-1:0]      operand;
    logic [$clog2(DIGITS+1)-1:0]    count;
    logic                           full;
    logic                           rejected;
    modport master (output key_n, sw_digit, busy, input start, operand, count, full, rejected);
    modport slave  (input key_n, sw_digit, busy, output start, operand, count, full, rejected);
endinterface

// File: rtl/key_operand_entry.sv
// key_operand_entry: debounced push-button digit entry building an operand and issuing one-cycle start requests.
module key_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIGITS          = 4,
    parameter int DIGIT_W         = 4
) (
    input  logic               clock,
    input  logic               reset,
    key_operand_entry_if.slave bus
);
    localparam int W  = DIGITS * DIGIT_W;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {ENTRY, WAIT_BUSY, RUN} state_t;

    logic [2:0]    sync1, sync2, stable, press;
    logic [DW-1:0] cnt [3];
    state_t        state, state_n;
    logic [W-1:0]  operand, operand_n;
    logic [CW-1:0] count, count_n;
    logic          start, start_n, rejected, rejected_n;
    logic          ent, clr, sub;

    // press is registered alongside the stable-level flip, so it lasts exactly one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            press  <= '0;
            cnt    <= '{default: '0};
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] == stable[k]) cnt[k] <= '0;
                else if (cnt[k] == DB_MAX) begin
                    cnt[k]    <= '0;
                    stable[k] <= sync2[k];
                    press[k]  <= stable[k];
                end else cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    assign ent = press[0];
    assign clr = press[1];
    assign sub = press[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ENTRY;
            operand  <= '0;
            count    <= '0;
            start    <= 1'b0;
            rejected <= 1'b0;
        end else begin
            state    <= state_n;
            operand  <= operand_n;
            count    <= count_n;
            start    <= start_n;
            rejected <= rejected_n;
        end
    end

    // clear outranks submit, which outranks enter
    always_comb begin
        state_n    = state;
        operand_n  = operand;
        count_n    = count;
        start_n    = 1'b0;
        rejected_n = 1'b0;
        case (state)
            ENTRY: begin
                if (clr) begin
                    operand_n = '0;
                    count_n   = '0;
                end else if (sub) begin
                    if (count != '0 && !bus.busy) begin
                        start_n = 1'b1;
                        state_n = WAIT_BUSY;
                    end else rejected_n = 1'b1;
                end else if (ent) begin
                    if (bus.full) rejected_n = 1'b1;
                    else begin
                        operand_n = {operand[W-DIGIT_W-1:0], bus.sw_digit};
                        count_n   = count + 1'b1;
                    end
                end
            end
            WAIT_BUSY: begin
                if (clr) begin
                    state_n   = ENTRY;
                    operand_n = '0;
                    count_n   = '0;
                end else begin
                    rejected_n = sub | ent;
                    if (bus.busy) state_n = RUN;
                end
            end
            RUN: begin
                rejected_n = |press;
                if (!bus.busy) begin
                    state_n   = ENTRY;
                    operand_n = '0;
                    count_n   = '0;
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    assign bus.operand  = operand;
    assign bus.count    = count;
    assign bus.full     = count == CW'(DIGITS);
    assign bus.start    = start;
    assign bus.rejected = rejected;
endmodule

// File: tb/tb_key_operand_entry.sv
// tb_key_operand_entry: directed key-entry scenarios with immediate assertions against hand-computed values.
module tb_key_operand_entry;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   rej_n    = 0;
    int   st_n     = 0;
    int   rej0, st0;

    always #5 clock = ~clock;

    key_operand_entry_if bus ();

    key_operand_entry #(.DEBOUNCE_CYCLES(4), .DIGITS(4), .DIGIT_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // count cycles in which the single-cycle outputs are high
    always @(negedge clock) begin
        if (!reset) begin
            rej_n = rej_n + int'(bus.rejected);
            st_n  = st_n + int'(bus.start);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tap(input int k, input int hold);
        @(negedge clock) bus.key_n[k] = 1'b0;
        repeat (hold) @(negedge clock);
        bus.key_n[k] = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic enter(input logic [3:0] d);
        bus.sw_digit = d;
        tap(0, 8);
    endtask

    initial begin
        bus.key_n    = 3'b111;
        bus.sw_digit = 4'h0;
        bus.busy     = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_operand", 32'(bus.operand), 32'h0);
        chk("reset_count", 32'(bus.count), 32'h0);
        chk("reset_full", 32'(bus.full), 32'h0);
        chk("reset_start", 32'(bus.start), 32'h0);
        chk("reset_rejected", 32'(bus.rejected), 32'h0);
        reset = 1'b0;

        // 1: three digits
        enter(4'h3); enter(4'hA); enter(4'h5);
        chk("s1_operand", 32'(bus.operand), 32'h03A5);
        chk("s1_count", 32'(bus.count), 32'd3);
        chk("s1_no_start", 32'(st_n), 32'd0);

        // 2: fill then overflow
        tap(1, 8);
        chk("s2_clear", 32'(bus.operand), 32'h0);
        enter(4'h1); enter(4'h2); enter(4'h3); enter(4'h4);
        chk("s2_operand", 32'(bus.operand), 32'h1234);
        chk("s2_full", 32'(bus.full), 32'd1);
        rej0 = rej_n;
        enter(4'h7);
        chk("s2_reject", 32'(rej_n - rej0), 32'd1);
        chk("s2_no_shift", 32'(bus.operand), 32'h1234);
        chk("s2_count", 32'(bus.count), 32'd4);

        // 3: submit, busy handshake, return to entry
        tap(1, 8);
        enter(4'h4); enter(4'h2);
        chk("s3_operand", 32'(bus.operand), 32'h0042);
        st0 = st_n;
        tap(2, 8);
        chk("s3_start_one_cycle", 32'(st_n - st0), 32'd1);
        rej0 = rej_n;
        enter(4'h9);
        chk("s3_wait_reject", 32'(rej_n - rej0), 32'd1);
        chk("s3_wait_frozen", 32'(bus.operand), 32'h0042);
        bus.busy = 1'b1;
        repeat (3) @(negedge clock);
        rej0 = rej_n;
        tap(1, 8);
        chk("s3_run_clear_rejected", 32'(rej_n - rej0), 32'd1);
        chk("s3_run_frozen", 32'(bus.operand), 32'h0042);
        bus.busy = 1'b0;
        @(negedge clock);
        chk("s3_done_operand", 32'(bus.operand), 32'h0);
        chk("s3_done_count", 32'(bus.count), 32'd0);
        chk("s3_no_extra_start", 32'(st_n - st0), 32'd1);
        enter(4'h6);
        chk("s3_back_in_entry", 32'(bus.operand), 32'h0006);

        // 4: rejected submits
        tap(1, 8);
        st0 = st_n;
        rej0 = rej_n;
        tap(2, 8);
        chk("s4_empty_reject", 32'(rej_n - rej0), 32'd1);
        enter(4'h9);
        bus.busy = 1'b1;
        rej0 = rej_n;
        tap(2, 8);
        chk("s4_busy_reject", 32'(rej_n - rej0), 32'd1);
        chk("s4_no_start", 32'(st_n - st0), 32'd0);
        bus.busy = 1'b0;
        chk("s4_operand", 32'(bus.operand), 32'h0009);

        // 5: glitch and long hold
        bus.sw_digit = 4'hC;
        tap(0, 2);
        chk("s5_glitch_count", 32'(bus.count), 32'd1);
        chk("s5_glitch_operand", 32'(bus.operand), 32'h0009);
        tap(0, 50);
        chk("s5_hold_count", 32'(bus.count), 32'd2);
        chk("s5_hold_operand", 32'(bus.operand), 32'h009C);

        // 6: reset while running, then clear beats enter
        tap(1, 8);
        enter(4'hF); enter(4'hF);
        chk("s6_operand", 32'(bus.operand), 32'h00FF);
        tap(2, 8);
        bus.busy = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("s6_rst_operand", 32'(bus.operand), 32'h0);
        chk("s6_rst_count", 32'(bus.count), 32'd0);
        chk("s6_rst_full", 32'(bus.full), 32'd0);
        chk("s6_rst_start", 32'(bus.start), 32'd0);
        reset = 1'b0;
        bus.busy = 1'b0;
        enter(4'h1); enter(4'h2);
        chk("s6_pre_count", 32'(bus.count), 32'd2);
        bus.sw_digit = 4'h8;
        @(negedge clock) bus.key_n = 3'b100;
        repeat (8) @(negedge clock);
        bus.key_n = 3'b111;
        repeat (10) @(negedge clock);
        chk("s6_clear_wins_operand", 32'(bus.operand), 32'h0);
        chk("s6_clear_wins_count", 32'(bus.count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
